flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit.sv | 151 +++++++++++++++
 tb/tb_flag_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// flag_unit -- condition-flag register with optional shadow save stack.
//
// Holds NUM_FLAGS condition flags written by the ALU under a per-bit
// write mask, evaluates a 3-bit branch condition against the committed
// flags, and optionally saves/restores the flags on a small LIFO stack.
//
// Build option: define FLAG_SHADOW_EN to include the shadow stack.
// Without it, push/pop are ignored, shadow_full=0, shadow_empty=1 and
// shadow_err=0.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   flags_in     new flag values (bit 2 = N, bit 1 = Z, bit 0 = V)
//   flag_we      per-flag write-enable mask
//   stall        freeze every piece of state this cycle
//   flush        drop this cycle's flag write (push/pop still honoured)
//   push / pop   save current flags / restore flags from stack top
//   cond         branch condition code
//   flags_out    committed flag register
//   cond_true    condition result, from flags_out only (no bypass)
//   shadow_full / shadow_empty / shadow_err   stack status, err is sticky

module flag_unit #(
   parameter int NUM_FLAGS    = 3,
   parameter int SHADOW_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_FLAGS-1:0] flags_in,
   input  logic [NUM_FLAGS-1:0] flag_we,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 push,
   input  logic                 pop,
   input  logic [2:0]           cond,
   output logic [NUM_FLAGS-1:0] flags_out,
   output logic                 cond_true,
   output logic                 shadow_full,
   output logic                 shadow_empty,
   output logic                 shadow_err
);

   logic [NUM_FLAGS-1:0] flags_q;
   logic [NUM_FLAGS-1:0] flags_d;
   logic [NUM_FLAGS-1:0] wr_flags;

   // Masked ALU write; flush keeps the old value of every bit.
   assign wr_flags = flush ? flags_q
                           : ((flags_q & ~flag_we) | (flags_in & flag_we));

`ifdef FLAG_SHADOW_EN
   localparam int PTR_W = $clog2(SHADOW_DEPTH + 1);

   logic [PTR_W-1:0]     ptr_q;
   logic [PTR_W-1:0]     ptr_d;
   logic                 err_q;
   logic                 err_d;
   logic [NUM_FLAGS-1:0] stack_q [SHADOW_DEPTH];
   logic [NUM_FLAGS-1:0] top_flags;
   logic                 full;
   logic                 empty;
   logic                 push_ok;
   logic                 pop_ok;

   assign full    = (ptr_q == PTR_W'(SHADOW_DEPTH));
   assign empty   = (ptr_q == '0);
   // Simultaneous push and pop cancel each other without an error.
   assign push_ok = push & ~pop & ~full;
   assign pop_ok  = pop & ~push & ~empty;

   // Top entry sits at ptr_q-1; compare-select keeps the index in range
   // for depths that are not a power of two.
   always_comb begin
      top_flags = '0;
      for (int i = 0; i < SHADOW_DEPTH; i++) begin
         if (ptr_q == PTR_W'(i + 1)) top_flags = stack_q[i];
      end
   end

   always_comb begin
      flags_d = pop_ok ? top_flags : wr_flags;
      ptr_d   = ptr_q;
      if (push_ok)     ptr_d = ptr_q + PTR_W'(1);
      else if (pop_ok) ptr_d = ptr_q - PTR_W'(1);
      err_d   = err_q | (push & ~pop & full) | (pop & ~push & empty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else if (!stall) begin
         flags_q <= flags_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   // Stack contents carry no reset; the pointer alone defines validity.
   always_ff @(posedge clk) begin
      if (!stall && push_ok) begin
         for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (ptr_q == PTR_W'(i)) stack_q[i] <= flags_q;
         end
      end
   end

   assign shadow_full  = full;
   assign shadow_empty = empty;
   assign shadow_err   = err_q;
`else
   logic unused_shadow;

   assign flags_d = wr_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      flags_q <= '0;
      else if (!stall) flags_q <= flags_d;
   end

   assign unused_shadow = push ^ pop ^ ((SHADOW_DEPTH > 0) ? 1'b0 : 1'b1);
   assign shadow_full   = 1'b0;
   assign shadow_empty  = 1'b1;
   assign shadow_err    = 1'b0;
`endif

   assign flags_out = flags_q;

   always_comb begin
      logic n_f;
      logic z_f;
      logic v_f;
      n_f = flags_q[2];
      z_f = flags_q[1];
      v_f = flags_q[0];
      cond_true = 1'b0;
      case (cond)
         3'b000: cond_true = ~z_f;
         3'b001: cond_true = z_f;
         3'b010: cond_true = ~z_f & ~n_f;
         3'b011: cond_true = n_f;
         3'b100: cond_true = z_f | (~z_f & ~n_f);
         3'b101: cond_true = n_f | z_f;
         3'b110: cond_true = v_f;
         default: cond_true = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

   localparam int NF    = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NF-1:0] flags_in = '0;
   logic [NF-1:0] flag_we = '0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [2:0]    cond = 3'b000;
   logic [NF-1:0] flags_out;
   logic          cond_true;
   logic          shadow_full;
   logic          shadow_empty;
   logic          shadow_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Reference model state: flags, sticky error, stack as a queue.
   logic [NF-1:0] m_flags = '0;
   bit            m_err = 1'b0;
   logic [NF-1:0] m_stack [$];

   // Row c, bit f = expected cond_true for cond c and flags f ({N,Z,V}).
   logic [7:0] cond_tbl [8] = '{8'h33, 8'hCC, 8'h03, 8'hF0,
                                8'hCF, 8'hFC, 8'hAA, 8'hFF};

   flag_unit #(.NUM_FLAGS(NF), .SHADOW_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flags_in     (flags_in),
      .flag_we      (flag_we),
      .stall        (stall),
      .flush        (flush),
      .push         (push),
      .pop          (pop),
      .cond         (cond),
      .flags_out    (flags_out),
      .cond_true    (cond_true),
      .shadow_full  (shadow_full),
      .shadow_empty (shadow_empty),
      .shadow_err   (shadow_err)
   );

   always #5 clk = ~clk;

   function automatic bit cond_model(logic [2:0] f, logic [2:0] c);
      bit n, z, v;
      n = f[2]; z = f[1]; v = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit m_full();
`ifdef FLAG_SHADOW_EN
      return m_stack.size() == DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_empty();
`ifdef FLAG_SHADOW_EN
      return m_stack.size() == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model update.
   always @(posedge clk or negedge rst_n) begin
      logic [NF-1:0] nf;
      if (!rst_n) begin
         m_flags = '0;
         m_err   = 1'b0;
         m_stack.delete();
      end else if (!stall) begin
         nf = m_flags;
         if (!flush)
            for (int i = 0; i < NF; i++) if (flag_we[i]) nf[i] = flags_in[i];
`ifdef FLAG_SHADOW_EN
         if (push && !pop) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_flags);
         end
         if (pop && !push) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else nf = m_stack.pop_back();
         end
`endif
         m_flags = nf;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("flags_out", 32'(flags_out), 32'(m_flags));
         chk("cond_true", 32'(cond_true), 32'(cond_model(m_flags, cond)));
         chk("shadow_full", 32'(shadow_full), 32'(m_full()));
         chk("shadow_empty", 32'(shadow_empty), 32'(m_empty()));
         chk("shadow_err", 32'(shadow_err), 32'(m_err));
      end
   end

   task automatic step(input logic [2:0] fi, input logic [2:0] we,
                       input logic st, input logic fl, input logic pu, input logic po);
      flags_in = fi; flag_we = we; stall = st; flush = fl; push = pu; pop = po;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held low: outputs forced.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flags", 32'(flags_out), 32'h0);
      chk("rst_empty", 32'(shadow_empty), 32'h1);
      chk("rst_full", 32'(shadow_full), 32'h0);
      chk("rst_err", 32'(shadow_err), 32'h0);
      check_en = 1'b1;
      rst_n = 1'b1;

      // Masked write.
      cond = 3'b001;
      step(3'b111, 3'b010, 0, 0, 0, 0);
      chk("masked_write", 32'(flags_out), 32'h2);
      chk("masked_cond", 32'(cond_true), 32'h1);

      // Stall, then flush, then a real write.
      step(3'b101, 3'b111, 1, 0, 0, 0);
      chk("stall_hold", 32'(flags_out), 32'h2);
      step(3'b101, 3'b111, 0, 1, 0, 0);
      chk("flush_hold", 32'(flags_out), 32'h2);
      step(3'b101, 3'b111, 0, 0, 0, 0);
      chk("write_after", 32'(flags_out), 32'h5);

      // Push with concurrent write, then pop overriding the write mask.
      step(3'b100, 3'b111, 0, 0, 0, 0);
      step(3'b001, 3'b111, 0, 0, 1, 0);
      chk("push_write", 32'(flags_out), 32'h1);
      step(3'b010, 3'b111, 0, 0, 0, 1);
`ifdef FLAG_SHADOW_EN
      chk("pop_restore", 32'(flags_out), 32'h4);
      chk("pop_empty", 32'(shadow_empty), 32'h1);
`else
      chk("pop_ignored", 32'(flags_out), 32'h2);
`endif

      // Push and pop together: write proceeds, no error.
      step(3'b011, 3'b111, 0, 0, 1, 1);
      chk("pushpop_flags", 32'(flags_out), 32'h3);
      chk("pushpop_err", 32'(shadow_err), 32'h0);
      // Stall blocks a push.
      step(3'b000, 3'b000, 1, 0, 1, 0);
      chk("stall_push", 32'(shadow_empty), 32'h1);
      // Push under flush is accepted; write suppressed.
      step(3'b110, 3'b111, 0, 1, 1, 0);
      chk("flush_push_flags", 32'(flags_out), 32'h3);
      step(3'b101, 3'b111, 0, 0, 0, 0);
      step(3'b111, 3'b111, 0, 1, 0, 1);
`ifdef FLAG_SHADOW_EN
      chk("flush_pop_flags", 32'(flags_out), 32'h3);
      chk("flush_pop_empty", 32'(shadow_empty), 32'h1);
`else
      chk("flush_pop_flags", 32'(flags_out), 32'h5);
`endif

      // Overflow and underflow.
      step(3'b011, 3'b111, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(3'(k + 1), 3'b111, 0, 0, 1, 0);
`ifdef FLAG_SHADOW_EN
         if (k == 3) begin
            chk("ovf_full4", 32'(shadow_full), 32'h1);
            chk("ovf_err4", 32'(shadow_err), 32'h0);
         end
`endif
      end
`ifdef FLAG_SHADOW_EN
      chk("ovf_full5", 32'(shadow_full), 32'h1);
      chk("ovf_err5", 32'(shadow_err), 32'h1);
`else
      chk("nopush_full", 32'(shadow_full), 32'h0);
      chk("nopush_err", 32'(shadow_err), 32'h0);
`endif
      chk("ovf_flags", 32'(flags_out), 32'h5);
      for (int k = 0; k < 5; k++) begin
         step(3'b000, 3'b000, 0, 0, 0, 1);
`ifdef FLAG_SHADOW_EN
         if (k == 3) chk("unf_pop4_flags", 32'(flags_out), 32'h3);
`endif
      end
      chk("unf_empty", 32'(shadow_empty), 32'h1);
`ifdef FLAG_SHADOW_EN
      chk("unf_err", 32'(shadow_err), 32'h1);
`else
      chk("unf_err", 32'(shadow_err), 32'h0);
      chk("unf_flags", 32'(flags_out), 32'h5);
`endif

      // Asynchronous reset mid-cycle with two entries stacked.
      step(3'b111, 3'b111, 0, 0, 1, 0);
      step(3'b111, 3'b111, 0, 0, 1, 0);
      flags_in = '0; flag_we = '0; push = 1'b0;
      chk("pre_rst_flags", 32'(flags_out), 32'h7);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_flags", 32'(flags_out), 32'h0);
      chk("arst_empty", 32'(shadow_empty), 32'h1);
      chk("arst_err", 32'(shadow_err), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(3'b110, 3'b111, 0, 0, 0, 0);
      chk("post_rst_write", 32'(flags_out), 32'h6);
      step(3'b000, 3'b000, 0, 0, 0, 1);
`ifdef FLAG_SHADOW_EN
      chk("post_rst_underflow", 32'(shadow_err), 32'h1);
`else
      chk("post_rst_err", 32'(shadow_err), 32'h0);
`endif

      // Condition table sweep.
      for (int f = 0; f < 8; f++) begin
         step(3'(f), 3'b111, 0, 0, 0, 0);
         for (int c = 0; c < 8; c++) begin
            logic [7:0] row;
            cond = 3'(c);
            step(3'b000, 3'b000, 0, 0, 0, 0);
            row = cond_tbl[c];
            chk($sformatf("cond_tbl_c%0d_f%0d", c, f), 32'(cond_true), 32'(row[f]));
         end
      end

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         cond = 3'($urandom_range(0, 7));
         step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
